multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Drives the 3-bit ALUOp class code that ALU_Control consumes, plus datapath mux selects, register/PC/IR write enables and memory request handshakes.
- Detects illegal opcodes and memory timeouts, and parks in a TRAP state when either occurs.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for imem_ready or dmem_ready before trapping; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the IR (valid from DECODE onward)
- alu_zero  in  1  ALU zero flag, valid during EXECUTE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load (valid when dmem_req=1)
- ir_write  out  1  latch fetched instruction and old PC
- pc_write  out  1  PC register load enable
- pc_src  out  2  00 = pc+4, 01 = ALU result, 10 = branch target
- alu_op  out  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 LI (load), 111 LJ (JALR)
- alu_src_a  out  2  00 = rs1, 01 = old PC, 10 = zero
- alu_src_b  out  1  0 = rs2, 1 = imm
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 = ALU, 01 = mem data, 10 = old pc+4
- trap  out  1  sticky: illegal opcode or timeout
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout

Behaviour:
- Reset: state = FETCH, wait counter = 0, trap = 0, trap_cause = 0.
- Reset: every enable/request output = 0; every select output and alu_op = 0.
- All outputs are Moore-decoded from state and the latched opcode, except where marked (gated by a ready or alu_zero).
- FETCH:
  - imem_req = 1, held until imem_ready.
  - Cycle with imem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00; go to DECODE.
- DECODE: one cycle, no enables.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 0010111 AUIPC, 0110111 LUI, 1101111 JAL, 1100111 JALR.
  - Any other opcode: go to TRAP with trap_cause = 0. Otherwise go to EXECUTE.
- EXECUTE: one cycle; alu_op is the class code for the opcode.
  - R: a = rs1, b = rs2; go to WB.
  - I: a = rs1, b = imm; go to WB.
  - Load: alu_op = 110, a = rs1, b = imm; go to MEM.
  - Store: alu_op = 010, a = rs1, b = imm; go to MEM.
  - Branch: alu_op = 011, a = rs1, b = rs2.
    - pc_write = alu_zero (combinational gating), pc_src = 10.
    - Go to FETCH.
  - AUIPC: alu_op = 100, a = PC, b = imm; go to WB.
  - LUI: alu_op = 100, a = zero, b = imm; go to WB.
  - JAL: alu_op = 101, a = PC, b = imm; pc_write = 1, pc_src = 01; go to WB.
  - JALR: alu_op = 111, a = rs1, b = imm; pc_write = 1, pc_src = 01; go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for store, 0 for load; held until dmem_ready.
  - alu_op and selects hold their EXECUTE values.
  - On dmem_ready: store goes to FETCH, load goes to WB.
- WB: one cycle, reg_write = 1.
  - wb_sel = 01 for load, 10 for JAL/JALR, 00 otherwise.
  - Go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle the ready input is low while in that state.
  - Counter reaching MEM_TIMEOUT with ready still low: go to TRAP with trap_cause = 1.
  - Ready arriving in the same cycle the counter hits MEM_TIMEOUT: ready wins and no trap is taken.
- TRAP: all enables and requests = 0, trap = 1. Held until rst.
- Reset mid-instruction: the next cycle is FETCH with all outputs at reset values. Any in-flight request is dropped and no write enable is asserted.
- A request stays asserted every cycle until its ready arrives; it never deasserts early.

Test Plan:
- R-type: opcode 0110011, imem_ready on the 1st cycle, no data access → exactly 4 cycles FETCH→DECODE→EXECUTE→WB. alu_op = 000 in EXECUTE; reg_write = 1 and wb_sel = 00 in WB.
- Load: opcode 0000011, dmem_ready after 3 wait cycles → dmem_req high for 4 cycles with dmem_we = 0. alu_op = 110 throughout MEM; reg_write = 1 and wb_sel = 01 one cycle after ready.
- Branch: opcode 1100011 run twice → alu_zero = 1 gives pc_write = 1, pc_src = 10 in EXECUTE. alu_zero = 0 gives pc_write = 0. Neither case asserts reg_write.
- JAL / JALR:
  - JAL 1101111 → EXECUTE: alu_op = 101, alu_src_a = 01, pc_write = 1, pc_src = 01; WB: wb_sel = 10.
  - JALR 1100111 → same sequence with alu_op = 111, alu_src_a = 00.
- Illegal and timeout:
  - Opcode 1111111 → trap = 1, trap_cause = 0 the cycle after DECODE, sticky.
  - imem_ready held low → trap_cause = 1 after MEM_TIMEOUT (15) wait cycles.
  - imem_ready arriving exactly at count 15 → no trap.
- Reset during MEM (dmem_req = 1) → next cycle FETCH, dmem_req = 0, imem_req = 1, trap = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) and drives the
// datapath controls. Illegal opcodes and memory timeouts park the FSM in TRAP
// until reset.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   opcode               instr[6:0] from the IR (valid from DECODE onward)
//   alu_zero             ALU zero flag (EXECUTE)
//   imem_ready/dmem_ready  memory handshake returns
//   imem_req, dmem_req, dmem_we        memory requests
//   ir_write, pc_write, pc_src         IR / PC update controls
//   alu_op, alu_src_a, alu_src_b       ALU class code and operand selects
//   reg_write, wb_sel                  register file write-back controls
//   trap, trap_cause                   sticky trap flag and its cause
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic       trap_cause
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       opc_q, opc_d;
  logic             cause_q, cause_d;

  // Per-class controls decoded from the opcode latched in DECODE
  logic       opc_legal;
  logic [2:0] cls_op;
  logic [1:0] cls_a;
  logic       cls_b;
  logic       is_load, is_store, is_branch, is_jump;

  // Legality is judged on the live IR opcode during DECODE
  always_comb begin
    opc_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: opc_legal = 1'b1;
      default: opc_legal = 1'b0;
    endcase
  end

  // Class decode of the latched opcode
  always_comb begin
    cls_op    = 3'b000;
    cls_a     = 2'b00;
    cls_b     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opc_q)
      OP_I:      begin cls_op = 3'b001; cls_b = 1'b1; end
      OP_LOAD:   begin cls_op = 3'b110; cls_b = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin cls_op = 3'b010; cls_b = 1'b1; is_store = 1'b1; end
      OP_BRANCH: begin cls_op = 3'b011; is_branch = 1'b1; end
      OP_AUIPC:  begin cls_op = 3'b100; cls_a = 2'b01; cls_b = 1'b1; end
      OP_LUI:    begin cls_op = 3'b100; cls_a = 2'b10; cls_b = 1'b1; end
      OP_JAL:    begin cls_op = 3'b101; cls_a = 2'b01; cls_b = 1'b1; is_jump = 1'b1; end
      OP_JALR:   begin cls_op = 3'b111; cls_b = 1'b1; is_jump = 1'b1; end
      default:   cls_op = 3'b000;
    endcase
  end

  // State, wait counter, latched opcode and trap cause
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      opc_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      cause_q <= cause_d;
    end
  end

  // Next state and Moore outputs (ready / alu_zero gate a few enables)
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;        // cleared unless a wait is in progress
    opc_d      = opc_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    trap       = 1'b0;
    trap_cause = cause_q;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (opc_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end
      end
      S_EXECUTE: begin
        alu_op    = cls_op;
        alu_src_a = cls_a;
        alu_src_b = cls_b;
        if (is_branch) begin
          pc_write = alu_zero;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end else if (is_jump) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
          state_d  = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = cls_op;
        alu_src_a = cls_a;
        alu_src_b = cls_b;
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        // Ready in the same cycle as the timeout count wins
        if (dmem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        alu_op    = cls_op;
        alu_src_a = cls_a;
        alu_src_b = cls_b;
        reg_write = 1'b1;
        wb_sel    = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is asserted nothing is requested or written
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_op     = 3'b000;
      alu_src_a  = 2'b00;
      alu_src_b  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = 2'b00;
      trap       = 1'b0;
      trap_cause = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each scenario
// queues per-cycle stimulus with its expected output vector, then replays it.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       alu_zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, wb_sel;
  logic [2:0] alu_op;
  logic       alu_src_b, reg_write, trap, trap_cause;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       trap;
    logic       trap_cause;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic       imem_ready;
    logic       dmem_ready;
    logic       alu_zero;
    logic [6:0] opcode;
  } stim_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  stim_t      sq[$];
  outs_t      eq[$];
  logic [6:0] op = 7'd0;
  outs_t      obs;
  outs_t      e;
  int         total = 0;
  int         bad = 0;

  assign obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_op,
                alu_src_a, alu_src_b, reg_write, wb_sel, trap, trap_cause};

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // Expected-vector builders
  function automatic outs_t e_fetch(input logic rdy);
    outs_t v = '0;
    v.imem_req = 1'b1;
    v.ir_write = rdy;
    v.pc_write = rdy;
    return v;
  endfunction

  function automatic outs_t e_ex(input logic [2:0] aop, input logic [1:0] a, input logic b,
                                 input logic pw, input logic [1:0] ps);
    outs_t v = '0;
    v.alu_op = aop; v.alu_src_a = a; v.alu_src_b = b;
    v.pc_write = pw; v.pc_src = ps;
    return v;
  endfunction

  function automatic outs_t e_mem(input logic [2:0] aop, input logic we);
    outs_t v = '0;
    v.dmem_req = 1'b1; v.dmem_we = we;
    v.alu_op = aop; v.alu_src_b = 1'b1;
    return v;
  endfunction

  function automatic outs_t e_wb(input logic [2:0] aop, input logic [1:0] a, input logic b,
                                 input logic [1:0] wb);
    outs_t v = '0;
    v.alu_op = aop; v.alu_src_a = a; v.alu_src_b = b;
    v.reg_write = 1'b1; v.wb_sel = wb;
    return v;
  endfunction

  function automatic outs_t e_trap(input logic cause);
    outs_t v = '0;
    v.trap = 1'b1; v.trap_cause = cause;
    return v;
  endfunction

  task automatic push(input logic r, input logic ir, input logic dr, input logic az,
                      input outs_t ex);
    sq.push_back({r, ir, dr, az, op});
    eq.push_back(ex);
  endtask

  // Drive one queued stimulus after the falling edge and settle
  task automatic apply_next();
    stim_t s;
    s = sq.pop_front();
    @(negedge clk);
    rst        = s.rst;
    imem_ready = s.imem_ready;
    dmem_ready = s.dmem_ready;
    alu_zero   = s.alu_zero;
    opcode     = s.opcode;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_r_type();
    op = OP_R;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b1, 1'b1, e_ex(3'b000, 2'b00, 1'b0, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b000, 2'b00, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL r_type cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_alu_classes();
    op = OP_I;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b001, 2'b00, 1'b1, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b001, 2'b00, 1'b1, 2'b00));
    op = OP_AUIPC;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b100, 2'b01, 1'b1, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b100, 2'b01, 1'b1, 2'b00));
    op = OP_LUI;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b100, 2'b10, 1'b1, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b100, 2'b10, 1'b1, 2'b00));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL alu_classes cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_load();
    op = OP_LOAD;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b110, 2'b00, 1'b1, 1'b0, 2'b00));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, e_mem(3'b110, 1'b0));
    push(1'b0, 1'b0, 1'b1, 1'b0, e_mem(3'b110, 1'b0));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b110, 2'b00, 1'b1, 2'b01));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL load cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_store();
    op = OP_STORE;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b010, 2'b00, 1'b1, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b1, 1'b0, e_mem(3'b010, 1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL store cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_branch();
    op = OP_BRANCH;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b1, e_ex(3'b011, 2'b00, 1'b0, 1'b1, 2'b10));
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b011, 2'b00, 1'b0, 1'b0, 2'b10));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL branch cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_jal_jalr();
    op = OP_JAL;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b101, 2'b01, 1'b1, 1'b1, 2'b01));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b101, 2'b01, 1'b1, 2'b10));
    op = OP_JALR;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b111, 2'b00, 1'b1, 1'b1, 2'b01));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b111, 2'b00, 1'b1, 2'b10));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL jal_jalr cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    op = OP_LOAD;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b110, 2'b00, 1'b1, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_mem(3'b110, 1'b0));
    push(1'b1, 1'b0, 1'b1, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    push(1'b0, 1'b0, 1'b1, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    op = OP_R;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'($urandom), 1'($urandom), e_trap(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL illegal cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_timeout();
    op = OP_R;
    push(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    push(1'b0, 1'b1, 1'b0, 1'b0, e_trap(1'b1));
    push(1'b0, 1'b1, 1'b1, 1'b0, e_trap(1'b1));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL imem_timeout cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_timeout_edge();
    op = OP_R;
    push(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b000, 2'b00, 1'b0, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_wb(3'b000, 2'b00, 1'b0, 2'b00));
    push(1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL timeout_edge cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  task automatic test_dmem_timeout();
    op = OP_LOAD;
    push(1'b0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, e_ex(3'b110, 2'b00, 1'b1, 1'b0, 2'b00));
    for (int i = 0; i < 16; i++) push(1'b0, 1'b0, 1'b0, 1'b0, e_mem(3'b110, 1'b0));
    push(1'b0, 1'b0, 1'b1, 1'b0, e_trap(1'b1));
    push(1'b0, 1'b1, 1'b1, 1'b0, e_trap(1'b1));
    for (int n = 0; sq.size() != 0; n++) begin
      apply_next();
      e = eq.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL dmem_timeout cyc=%0d got=%b exp=%b", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_alu_classes();
    test_load();
    test_store();
    test_branch();
    test_jal_jalr();
    test_reset_mid();
    test_illegal();
    test_timeout();
    test_timeout_edge();
    test_dmem_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
